// File: rtl/deslocador_serial_pkg.sv
// Shared types and constants for the serial shifter (package deslocador_pkg).
// ARITH_SHIFT_EN selects arithmetic right shifts and sign-change overflow.
package deslocador_pkg;

    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned SHAMT_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/deslocador_serial_if.sv
// Operand/result handshake bundle for deslocador_serial.
// master = producer/consumer side, slave = the shifter.
interface deslocador_serial_if import deslocador_pkg::*; #(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_dir;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_ovf;
    logic               out_sticky;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_sticky
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_sticky
    );

endinterface

// File: rtl/deslocador_serial_passo_deslocamento.sv
// Combinational single-position shifter used once per SHIFT cycle.
// With ARITH_SHIFT_EN it gains an arith-mode input and a sign-change output.
module passo_deslocamento import deslocador_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
`ifdef ARITH_SHIFT_EN
    input  logic             arith_i,
    output logic             sign_chg_o,
`endif
    output logic [WIDTH-1:0] data_o,
    output logic             lost_bit_o
);

    logic fill;

`ifdef ARITH_SHIFT_EN
    assign fill       = arith_i & data_i[WIDTH-1];
    // A left step flips the sign exactly when the two top bits differ.
    assign sign_chg_o = data_i[WIDTH-1] ^ data_i[WIDTH-2];
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        data_o     = data_i;
        lost_bit_o = 1'b0;
        if (dir_i == DIR_LEFT) begin
            data_o     = {data_i[WIDTH-2:0], 1'b0};
            lost_bit_o = data_i[WIDTH-1];
        end else begin
            data_o     = {fill, data_i[WIDTH-1:1]};
            lost_bit_o = data_i[0];
        end
    end

endmodule

// File: rtl/deslocador_serial.sv
// Iterative shifter: one bit position per clock, valid/ready on both sides.
// ARITH_SHIFT_EN: arithmetic right shift, left overflow on sign change.
module deslocador_serial import deslocador_pkg::*; #(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input logic                clk,
    input logic                rst,
    deslocador_serial_if.slave bus
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               ovf_q, ovf_d;
    logic               sticky_q, sticky_d;

    logic [WIDTH-1:0]   step_data;
    logic               step_lost;
    logic               ovf_step;
    logic               accept;

`ifdef ARITH_SHIFT_EN
    logic step_sign_chg;
`endif

    passo_deslocamento #(
        .WIDTH (WIDTH)
    ) u_passo (
        .data_i     (data_q),
        .dir_i      (dir_q),
`ifdef ARITH_SHIFT_EN
        .arith_i    (1'b1),
        .sign_chg_o (step_sign_chg),
`endif
        .data_o     (step_data),
        .lost_bit_o (step_lost)
    );

`ifdef ARITH_SHIFT_EN
    assign ovf_step = step_sign_chg;
`else
    assign ovf_step = step_lost;
`endif

    assign bus.in_ready   = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_data   = data_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_sticky = sticky_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d   = bus.in_data;
                    cnt_d    = bus.in_shamt;
                    dir_d    = bus.in_dir;
                    ovf_d    = 1'b0;
                    sticky_d = 1'b0;
                    // k = 0 still goes through DONE so the result is registered.
                    state_d  = (bus.in_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = step_data;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (dir_q == DIR_LEFT) begin
                    ovf_d = ovf_q | ovf_step;
                end else begin
                    sticky_d = sticky_q | step_lost;
                end
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_LEFT;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

endmodule
